// File: rtl/stdcore_pkg.sv
// -----------------------------------------------------------------------------
// stdcore_pkg
// Shared definitions for the SRAM read arbiter and its response skid.
//   CNT_LIMIT   : maximum reads in flight plus responses held in the skid
//   CNT_W       : width of the credit counter
//   RSP_DW_MAX  : widest response data a skid entry can carry
//   RSP_IW_MAX  : widest requester id a skid entry can carry
//   rsp_entry_t : one response entry (data, id)
// The entry uses fixed maximum widths so one type serves every arbiter
// instance. Narrower instances zero-extend into it, and the unused upper
// bits reduce to constant flops.
// -----------------------------------------------------------------------------
package stdcore_pkg;

    localparam int CNT_LIMIT  = 2;
    localparam int CNT_W      = 2;
    localparam int RSP_DW_MAX = 64;
    localparam int RSP_IW_MAX = 8;

    typedef struct packed {
        logic [RSP_DW_MAX-1:0] data;
        logic [RSP_IW_MAX-1:0] id;
    } rsp_entry_t;

endpackage

// File: rtl/stdcore_arb_skid.sv
// -----------------------------------------------------------------------------
// stdcore_arb_skid
// Two-entry synchronous FIFO for arbiter response entries. The head entry is
// held in a register and drives the response port directly.
// Ports:
//   i_clk, i_arst : clock, asynchronous active-high reset
//   i_push, i_din : write an entry (ignored when full with no pop)
//   i_pop         : remove the head entry (ignored when empty)
//   o_head        : current head entry
//   o_full        : two entries held
//   o_empty       : no entries held
// -----------------------------------------------------------------------------
module stdcore_arb_skid
    import stdcore_pkg::*;
#(
    parameter type T = rsp_entry_t
)
(
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic       i_push,
    input  T           i_din,
    input  logic       i_pop,
    output T           o_head,
    output logic       o_full,
    output logic       o_empty
);

    T           r_mem0;
    T           r_mem1;
    logic [1:0] r_count;

    logic       w_pop;
    logic       w_push;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
    assign o_head  = r_mem0;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= i_din;
                    end else begin
                        r_mem1 <= i_din;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_din;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/stdcore_sram_rdarb.sv
// -----------------------------------------------------------------------------
// stdcore_sram_rdarb
// Round-robin read arbiter that shares one SRAM read port among N requesters.
// Responses come back in issue order, tagged with the requester index.
// Optional feature macro: STDCORE_ARB_BURST_EN. When it is defined, the grant
// stays on the same requester for up to BURST consecutive grants.
// Ports:
//   clk, arst    : clock, asynchronous active-high reset
//   req_addr     : requester i address at [i*AW +: AW]
//   req_val      : per-requester valid
//   req_rdy      : per-requester accept (one-hot or zero)
//   sram_raddr   : SRAM read address (holds its last value when idle)
//   sram_re_n    : SRAM read enable, active-low
//   sram_rdata   : SRAM read data, valid the cycle after the read
//   rsp_data     : response data
//   rsp_id       : response owner
//   rsp_val      : response valid
//   rsp_rdy      : response consumer ready
// -----------------------------------------------------------------------------
module stdcore_sram_rdarb
    import stdcore_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int AW    = 16,
    parameter  int DW    = 16,
    parameter  int BURST = 4,
    localparam int IW    = $clog2(N)
)
(
    input  logic            clk,
    input  logic            arst,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N-1:0]    req_val,
    output logic [N-1:0]    req_rdy,
    output logic [AW-1:0]   sram_raddr,
    output logic            sram_re_n,
    input  logic [DW-1:0]   sram_rdata,
    output logic [DW-1:0]   rsp_data,
    output logic [IW-1:0]   rsp_id,
    output logic            rsp_val,
    input  logic            rsp_rdy
);

    logic [IW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_raddr;
    logic             r_rd_pend;
    logic [IW-1:0]    r_rd_id;

    logic             w_rr_hit;
    logic [IW-1:0]    w_rr_idx;
    logic [IW-1:0]    w_cand;
    logic             w_gnt_hit;
    logic [IW-1:0]    w_gnt_idx;
    logic             w_pop;
    logic             w_issue_ok;
    logic             w_issue;
    logic [AW-1:0]    w_gnt_addr;

    rsp_entry_t       w_din;
    rsp_entry_t       w_head;
    logic             w_skid_full;
    logic             w_skid_empty;
    logic             w_unused_bits;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        w_cand   = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(r_ptr) + k) % N);
            if (!w_rr_hit && req_val[w_cand]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_cand;
            end
        end
    end

`ifdef STDCORE_ARB_BURST_EN
    localparam int BW = $clog2(BURST + 1);

    logic [BW-1:0] r_burst;
    logic          w_hold;

    // A nonzero count means r_ptr was granted last and its burst is still open.
    assign w_hold    = (r_burst != '0) && (int'(r_burst) < BURST) && req_val[r_ptr];
    assign w_gnt_hit = w_hold || w_rr_hit;
    assign w_gnt_idx = w_hold ? r_ptr : w_rr_idx;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_burst <= '0;
        end else if (w_issue) begin
            // A round-robin pick that lands back on the same requester starts a new burst.
            r_burst <= w_hold ? (r_burst + BW'(1)) : BW'(1);
        end else if (!req_val[r_ptr]) begin
            r_burst <= '0;
        end
    end
`else
    assign w_gnt_hit = w_rr_hit;
    assign w_gnt_idx = w_rr_idx;
`endif

    assign rsp_val    = !w_skid_empty;
    assign w_pop      = rsp_val && rsp_rdy;
    // A pop in this cycle frees a credit in time for a same-cycle issue.
    assign w_issue_ok = (int'(r_cnt) < CNT_LIMIT) || w_pop;
    assign w_issue    = w_gnt_hit && w_issue_ok && !arst;
    assign w_gnt_addr = req_addr[int'(w_gnt_idx)*AW +: AW];

    always_comb begin
        req_rdy = '0;
        if (w_issue) begin
            req_rdy[w_gnt_idx] = 1'b1;
        end
    end

    assign sram_re_n  = !w_issue;
    assign sram_raddr = w_issue ? w_gnt_addr : r_raddr;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ptr     <= IW'(N - 1);
            r_cnt     <= '0;
            r_raddr   <= '0;
            r_rd_pend <= 1'b0;
            r_rd_id   <= '0;
        end else begin
            r_rd_pend <= w_issue;
            if (w_issue) begin
                r_ptr   <= w_gnt_idx;
                r_raddr <= w_gnt_addr;
                r_rd_id <= w_gnt_idx;
            end
            if (w_issue && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_issue && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign w_din = '{data: RSP_DW_MAX'(sram_rdata), id: RSP_IW_MAX'(r_rd_id)};

    stdcore_arb_skid #(
        .T (rsp_entry_t)
    ) u_skid (
        .i_clk   (clk),
        .i_arst  (arst),
        .i_push  (r_rd_pend),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_skid_full),
        .o_empty (w_skid_empty)
    );

    assign rsp_data = w_head.data[DW-1:0];
    assign rsp_id   = w_head.id[IW-1:0];

    // The upper entry bits are always zero here, and full is implied by the credit count.
    assign w_unused_bits = ^{w_head, w_skid_full};

endmodule

// File: tb/tb_stdcore_sram_rdarb.sv
module tb_stdcore_sram_rdarb;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            arst;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_val;
    logic [N-1:0]    req_rdy;
    logic [AW-1:0]   sram_raddr;
    logic            sram_re_n;
    logic [DW-1:0]   sram_rdata = '0;
    logic [DW-1:0]   rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            rsp_val;
    logic            rsp_rdy;

    int checks   = 0;
    int failures = 0;

    stdcore_sram_rdarb #(.N(N), .AW(AW), .DW(DW), .BURST(4)) dut (
        .clk        (clk),
        .arst       (arst),
        .req_addr   (req_addr),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .sram_raddr (sram_raddr),
        .sram_re_n  (sram_re_n),
        .sram_rdata (sram_rdata),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_val    (rsp_val),
        .rsp_rdy    (rsp_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // SRAM read port: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (!sram_re_n) sram_rdata <= mem_f(sram_raddr);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        arst    = 1'b1;
        req_val = '0;
        rsp_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        req_val = '1;
        rsp_rdy = 1'b1;
        for (int i = 0; i < N; i++) set_addr(i, AW'(16'h0010 * (i + 1)));
        tick();
        #1;
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL reset_req_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        checks++; if (sram_re_n !== 1'b1) begin failures++; $display("FAIL reset_re_n got=%b exp=1", sram_re_n); end
        checks++; if (rsp_val !== 1'b0) begin failures++; $display("FAIL reset_rsp_val got=%b exp=0", rsp_val); end
        checks++; if (rsp_data !== 16'h0000) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        rsp_rdy = 1'b1;
        set_addr(1, 16'h0040);
        req_val = 4'b0010;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin failures++; $display("FAIL single_rdy got=%b exp=%b", req_rdy, 4'b0010); end
        checks++; if (sram_re_n !== 1'b0) begin failures++; $display("FAIL single_re_n got=%b exp=0", sram_re_n); end
        checks++; if (sram_raddr !== 16'h0040) begin failures++; $display("FAIL single_raddr got=%h exp=0040", sram_raddr); end
        tick();
        req_val = 4'b0000;
        #1;
        checks++; if (rsp_val !== 1'b0) begin failures++; $display("FAIL single_early_val got=%b exp=0", rsp_val); end
        checks++; if (sram_re_n !== 1'b1) begin failures++; $display("FAIL single_idle_re_n got=%b exp=1", sram_re_n); end
        checks++; if (sram_raddr !== 16'h0040) begin failures++; $display("FAIL single_raddr_hold got=%h exp=0040", sram_raddr); end
        tick();
        #1;
        checks++; if (rsp_val !== 1'b1) begin failures++; $display("FAIL single_rsp_val got=%b exp=1", rsp_val); end
        checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL single_rsp_id got=%0d exp=1", rsp_id); end
        checks++; if (rsp_data !== mem_f(16'h0040)) begin failures++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, mem_f(16'h0040)); end
        tick();
        #1;
        checks++; if (rsp_val !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", rsp_val); end
    endtask

`ifdef STDCORE_ARB_BURST_EN
    task automatic test_burst();
        int ord [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, AW'(16'h0100 * (i + 1)));
        rsp_rdy = 1'b1;
        req_val = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_rdy = 4'b0001 << ord[k];
            checks++; if (req_rdy !== exp_rdy) begin failures++; $display("FAIL burst_grant k=%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
            if (k >= 2) begin
                checks++; if (rsp_val !== 1'b1 || rsp_id !== IW'(ord[k-2])) begin failures++; $display("FAIL burst_rsp k=%0d got=%b/%0d exp=1/%0d", k, rsp_val, rsp_id, ord[k-2]); end
            end
            tick();
        end
        req_val = '0;
        repeat (4) tick();
    endtask
`else
    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        logic [AW-1:0] a;
        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, AW'(16'h0100 * (i + 1)));
        rsp_rdy = 1'b1;
        req_val = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++; if (req_rdy !== exp_rdy) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
            if (k >= 2) begin
                a = AW'(16'h0100 * (((k - 2) % 4) + 1));
                checks++; if (rsp_val !== 1'b1 || rsp_id !== IW'((k - 2) % 4)) begin failures++; $display("FAIL rr_rsp_id k=%0d got=%b/%0d exp=1/%0d", k, rsp_val, rsp_id, (k - 2) % 4); end
                checks++; if (rsp_data !== mem_f(a)) begin failures++; $display("FAIL rr_rsp_data k=%0d got=%h exp=%h", k, rsp_data, mem_f(a)); end
            end
            tick();
        end
        req_val = '0;
        repeat (4) tick();
    endtask
`endif

    task automatic test_backpressure();
        do_reset();
        rsp_rdy = 1'b0;
        req_val = 4'b0100;
        set_addr(2, 16'h0222);
        #1;
        checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL bp_accept0 got=%b exp=0100", req_rdy); end
        tick();
        set_addr(2, 16'h0333);
        #1;
        checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL bp_accept1 got=%b exp=0100", req_rdy); end
        tick();
        set_addr(2, 16'h0444);
        #1;
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL bp_stall got=%b exp=0000", req_rdy); end
        checks++; if (rsp_val !== 1'b1) begin failures++; $display("FAIL bp_rsp_val got=%b exp=1", rsp_val); end
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL bp_hold_rdy c=%0d got=%b exp=0000", c, req_rdy); end
            checks++; if (rsp_val !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== mem_f(16'h0222)) begin failures++; $display("FAIL bp_hold_rsp c=%0d got=%b/%0d/%h exp=1/2/%h", c, rsp_val, rsp_id, rsp_data, mem_f(16'h0222)); end
        end
        tick();
        rsp_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL bp_resume got=%b exp=0100", req_rdy); end
        checks++; if (sram_raddr !== 16'h0444) begin failures++; $display("FAIL bp_resume_addr got=%h exp=0444", sram_raddr); end
        checks++; if (rsp_data !== mem_f(16'h0222)) begin failures++; $display("FAIL bp_first_data got=%h exp=%h", rsp_data, mem_f(16'h0222)); end
        tick();
        req_val = '0;
        #1;
        checks++; if (rsp_val !== 1'b1 || rsp_data !== mem_f(16'h0333)) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/%h", rsp_val, rsp_data, mem_f(16'h0333)); end
        tick();
        #1;
        checks++; if (rsp_val !== 1'b1 || rsp_data !== mem_f(16'h0444)) begin failures++; $display("FAIL bp_third got=%b/%h exp=1/%h", rsp_val, rsp_data, mem_f(16'h0444)); end
        tick();
        #1;
        checks++; if (rsp_val !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", rsp_val); end
    endtask

    task automatic test_reset_midflight();
        int n_rsp;
        do_reset();
        rsp_rdy = 1'b0;
        set_addr(0, 16'h0A0A);
        req_val = 4'b0001;
        repeat (3) tick();
        #1;
        checks++; if (rsp_val !== 1'b1 || req_rdy !== 4'b0000) begin failures++; $display("FAIL mid_full got=%b/%b exp=1/0000", rsp_val, req_rdy); end
        arst = 1'b1;
        #1;
        checks++; if (rsp_val !== 1'b0) begin failures++; $display("FAIL mid_rsp_val got=%b exp=0", rsp_val); end
        checks++; if (req_rdy !== 4'b0000 || sram_re_n !== 1'b1) begin failures++; $display("FAIL mid_rdy_re got=%b/%b exp=0000/1", req_rdy, sram_re_n); end
        tick();
        checks++; if (rsp_val !== 1'b0) begin failures++; $display("FAIL mid_rsp_edge got=%b exp=0", rsp_val); end
        tick();
        arst = 1'b0;
        for (int i = 0; i < N; i++) set_addr(i, AW'(16'h0B0B + i));
        req_val = 4'b1111;
        rsp_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL mid_first_grant got=%b exp=0001", req_rdy); end
        tick();
        req_val = '0;
        n_rsp = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (rsp_val) begin
                n_rsp++;
                checks++; if (rsp_id !== 2'd0 || rsp_data !== mem_f(16'h0B0B)) begin failures++; $display("FAIL mid_rsp got=%0d/%h exp=0/%h", rsp_id, rsp_data, mem_f(16'h0B0B)); end
            end
            tick();
        end
        checks++; if (n_rsp !== 1) begin failures++; $display("FAIL mid_rsp_count got=%0d exp=1", n_rsp); end
    endtask

    task automatic test_random();
        logic [IW+DW-1:0] q [$];
        logic [IW+DW-1:0] exp_e;
        logic             pop;
        logic             exp_issue;
        int               gi;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            req_val = N'($urandom_range(0, 15));
            rsp_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
            #1;
            pop = rsp_val && rsp_rdy;
            exp_issue = (req_val != '0) && ((q.size() < 2) || pop);
            checks++; if ((req_rdy != '0) !== exp_issue) begin failures++; $display("FAIL rnd_issue cyc=%0d got=%b exp=%b", cyc, req_rdy, exp_issue); end
            checks++; if (((req_rdy & (req_rdy - 1'b1)) != '0) || ((req_rdy & ~req_val) != '0)) begin failures++; $display("FAIL rnd_onehot cyc=%0d got=%b exp=subset_of_%b", cyc, req_rdy, req_val); end
            if (pop) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rnd_spurious cyc=%0d got=%0d/%h exp=none", cyc, rsp_id, rsp_data);
                end else begin
                    exp_e = q.pop_front();
                    if ({rsp_id, rsp_data} !== exp_e) begin failures++; $display("FAIL rnd_rsp cyc=%0d got=%0d/%h exp=%0d/%h", cyc, rsp_id, rsp_data, exp_e[IW+DW-1:DW], exp_e[DW-1:0]); end
                end
            end
            if (req_rdy != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (req_rdy[i]) gi = i;
                checks++; if (sram_re_n !== 1'b0 || sram_raddr !== req_addr[gi*AW +: AW]) begin failures++; $display("FAIL rnd_sram cyc=%0d got=%b/%h exp=0/%h", cyc, sram_re_n, sram_raddr, req_addr[gi*AW +: AW]); end
                q.push_back({IW'(gi), mem_f(req_addr[gi*AW +: AW])});
            end
            checks++; if (q.size() > 2) begin failures++; $display("FAIL rnd_credit cyc=%0d got=%0d exp=le2", cyc, q.size()); end
            tick();
        end
        req_val = '0;
        rsp_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_val) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rnd_drain_spurious got=%0d/%h exp=none", rsp_id, rsp_data);
                end else begin
                    exp_e = q.pop_front();
                    if ({rsp_id, rsp_data} !== exp_e) begin failures++; $display("FAIL rnd_drain got=%0d/%h exp=%0d/%h", rsp_id, rsp_data, exp_e[IW+DW-1:DW], exp_e[DW-1:0]); end
                end
            end
            tick();
        end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d exp=0", q.size()); end
    endtask

    initial begin
        arst     = 1'b1;
        req_val  = '0;
        req_addr = '0;
        rsp_rdy  = 1'b0;
        test_reset();
        test_single();
`ifdef STDCORE_ARB_BURST_EN
        test_burst();
`else
        test_round_robin();
`endif
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
